// File: rtl/id_ex_pipe.sv
// ---------------------------------------------------------------------------------------------
// id_ex_pipe
//
// Purpose:
//   ID->EX pipeline register for the execute stage (ALU / NPC / NPCO-mux).
//   - Captures the decoded controls and operands of the ID-slot instruction.
//   - Resolves RAW hazards by forwarding from EX/MEM/WB, and stalls on a load-use hazard.
//   - Squashes the ID-slot instruction when EX resolves a taken jump/branch.
//
// Build option:
//   FORWARD_EN defined   : operands are forwarded (EX > MEM > WB > register file). Only a
//                          load in EX that feeds a used source stalls ID, for one cycle.
//   FORWARD_EN undefined : no forwarding. ID stalls while any EX/MEM/WB writer targets a used
//                          source, up to 3 cycles. The register file need not be write-first.
//
// Encodings:
//   NPC_PC4 = 2'd0 (sequential next PC, used for bubbles), WD_RAM = 2'd1 (load writeback).
//
// Ports:
//   cpu_clk, cpu_rst_n          clock (rising edge), asynchronous active-low reset
//   id_valid                    ID slot holds a real instruction
//   id_pc, id_ext               PC and sign-extended immediate of the ID instruction
//   id_rs1/2, id_rs1/2_used     source indices and whether each is actually read
//   id_rD1/2                    register-file read data
//   id_rd, id_alu_op, id_npc_op, id_npco_sel, id_alub_sel (1 = immediate),
//   id_rf_we, id_ram_we, id_wd_sel        decoded controls
//   ex_is_jump                  taken redirect from EX (combinational)
//   ex_wd                       EX-stage writeback value
//   mem_rd/mem_rf_we/mem_wd     MEM-stage writer
//   wb_rd/wb_rf_we/wb_wd        WB-stage writer
//   ex_*                        registered EX-slot fields, operands already resolved
//   stall_id                    hold PC and IF/ID this cycle (combinational)
//   flush_ifid                  squash IF/ID (equals ex_is_jump)
// ---------------------------------------------------------------------------------------------

module id_ex_pipe #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned REG_AW = 5
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,

    // ID stage
    input  logic              id_valid,
    input  logic [XLEN-1:0]   id_pc,
    input  logic [XLEN-1:0]   id_ext,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [XLEN-1:0]   id_rD1,
    input  logic [XLEN-1:0]   id_rD2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [3:0]        id_alu_op,
    input  logic [1:0]        id_npc_op,
    input  logic              id_npco_sel,
    input  logic              id_alub_sel,
    input  logic              id_rf_we,
    input  logic              id_ram_we,
    input  logic [1:0]        id_wd_sel,

    // Later stages
    input  logic              ex_is_jump,
    input  logic [XLEN-1:0]   ex_wd,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_rf_we,
    input  logic [XLEN-1:0]   mem_wd,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_rf_we,
    input  logic [XLEN-1:0]   wb_wd,

    // EX slot
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [XLEN-1:0]   ex_ext,
    output logic [XLEN-1:0]   ex_aluA,
    output logic [XLEN-1:0]   ex_aluB,
    output logic [XLEN-1:0]   ex_rD2,
    output logic [3:0]        ex_alu_op,
    output logic [1:0]        ex_npc_op,
    output logic              ex_npco_sel,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_rf_we,
    output logic              ex_ram_we,
    output logic [1:0]        ex_wd_sel,

    // Hazard control
    output logic              stall_id,
    output logic              flush_ifid
);

    localparam logic [1:0] NPC_PC4 = 2'd0;
    localparam logic [1:0] WD_RAM  = 2'd1;

    // ------------------------------------------------------------------------
    // EX slot registers
    // ------------------------------------------------------------------------
    logic              r_valid;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_ext;
    logic [XLEN-1:0]   r_alua;
    logic [XLEN-1:0]   r_alub;
    logic [XLEN-1:0]   r_rd2;
    logic [3:0]        r_alu_op;
    logic [1:0]        r_npc_op;
    logic              r_npco_sel;
    logic [REG_AW-1:0] r_rd;
    logic              r_rf_we;
    logic              r_ram_we;
    logic [1:0]        r_wd_sel;

    // ------------------------------------------------------------------------
    // Hazard detection
    // ------------------------------------------------------------------------
    // A writer hits a source only if the source is really read, is not x0, and the writer
    // will actually write that register.
    function automatic logic f_hit(input logic              used,
                                   input logic [REG_AW-1:0] src,
                                   input logic              wr_en,
                                   input logic [REG_AW-1:0] wr_rd);
        return used && (src != '0) && wr_en && (wr_rd == src);
    endfunction

    logic w_ex_wr;
    logic w_ex_hit1;
    logic w_ex_hit2;
    logic w_mem_hit1;
    logic w_mem_hit2;
    logic w_wb_hit1;
    logic w_wb_hit2;

    // Bubbles already carry rf_we = 0; the valid term keeps the rule explicit.
    assign w_ex_wr    = r_valid & r_rf_we;

    assign w_ex_hit1  = f_hit(id_rs1_used, id_rs1, w_ex_wr,   r_rd);
    assign w_ex_hit2  = f_hit(id_rs2_used, id_rs2, w_ex_wr,   r_rd);
    assign w_mem_hit1 = f_hit(id_rs1_used, id_rs1, mem_rf_we, mem_rd);
    assign w_mem_hit2 = f_hit(id_rs2_used, id_rs2, mem_rf_we, mem_rd);
    assign w_wb_hit1  = f_hit(id_rs1_used, id_rs1, wb_rf_we,  wb_rd);
    assign w_wb_hit2  = f_hit(id_rs2_used, id_rs2, wb_rf_we,  wb_rd);

    logic            w_hazard;
    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;

`ifdef FORWARD_EN
    // Only a load in EX cannot be forwarded: its data does not exist until MEM. One bubble
    // moves the load to MEM, after which mem_wd supplies the value.
    assign w_hazard = (r_wd_sel == WD_RAM) & (w_ex_hit1 | w_ex_hit2);

    always_comb begin
        w_rs1_val = id_rD1;
        if (id_rs1 == '0) begin
            w_rs1_val = '0;
        end else if (w_ex_hit1) begin
            w_rs1_val = ex_wd;
        end else if (w_mem_hit1) begin
            w_rs1_val = mem_wd;
        end else if (w_wb_hit1) begin
            w_rs1_val = wb_wd;
        end
    end

    always_comb begin
        w_rs2_val = id_rD2;
        if (id_rs2 == '0) begin
            w_rs2_val = '0;
        end else if (w_ex_hit2) begin
            w_rs2_val = ex_wd;
        end else if (w_mem_hit2) begin
            w_rs2_val = mem_wd;
        end else if (w_wb_hit2) begin
            w_rs2_val = wb_wd;
        end
    end
`else
    // Without forwarding, wait until every in-flight writer of a used source has retired.
    // Stalling on WB too means the register file is read only after the write has landed.
    assign w_hazard = w_ex_hit1 | w_ex_hit2 | w_mem_hit1 | w_mem_hit2 | w_wb_hit1 | w_wb_hit2;

    assign w_rs1_val = (id_rs1 == '0) ? '0 : id_rD1;
    assign w_rs2_val = (id_rs2 == '0) ? '0 : id_rD2;

    // Writeback values are only consumed by the forwarding build.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{ex_wd, mem_wd, wb_wd};
`endif

    // A redirect discards the ID instruction, so any hazard it carries is moot. The reset
    // term makes stall_id fall together with the registered outputs.
    assign stall_id   = cpu_rst_n & id_valid & ~ex_is_jump & w_hazard;
    assign flush_ifid = ex_is_jump;

    logic w_bubble;
    assign w_bubble = ex_is_jump | stall_id | ~id_valid;

    // ------------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------------
    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_ext      <= '0;
            r_alua     <= '0;
            r_alub     <= '0;
            r_rd2      <= '0;
            r_alu_op   <= '0;
            r_npc_op   <= NPC_PC4;
            r_npco_sel <= 1'b0;
            r_rd       <= '0;
            r_rf_we    <= 1'b0;
            r_ram_we   <= 1'b0;
            r_wd_sel   <= '0;
        end else if (w_bubble) begin
            // Bubble: no architectural effect, data fields cleared.
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_ext      <= '0;
            r_alua     <= '0;
            r_alub     <= '0;
            r_rd2      <= '0;
            r_alu_op   <= '0;
            r_npc_op   <= NPC_PC4;
            r_npco_sel <= 1'b0;
            r_rd       <= '0;
            r_rf_we    <= 1'b0;
            r_ram_we   <= 1'b0;
            r_wd_sel   <= '0;
        end else begin
            r_valid    <= 1'b1;
            r_pc       <= id_pc;
            r_ext      <= id_ext;
            r_alua     <= w_rs1_val;
            r_alub     <= id_alub_sel ? id_ext : w_rs2_val;
            r_rd2      <= w_rs2_val;
            r_alu_op   <= id_alu_op;
            r_npc_op   <= id_npc_op;
            r_npco_sel <= id_npco_sel;
            r_rd       <= id_rd;
            r_rf_we    <= id_rf_we;
            r_ram_we   <= id_ram_we;
            r_wd_sel   <= id_wd_sel;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_pc       = r_pc;
    assign ex_ext      = r_ext;
    assign ex_aluA     = r_alua;
    assign ex_aluB     = r_alub;
    assign ex_rD2      = r_rd2;
    assign ex_alu_op   = r_alu_op;
    assign ex_npc_op   = r_npc_op;
    assign ex_npco_sel = r_npco_sel;
    assign ex_rd       = r_rd;
    assign ex_rf_we    = r_rf_we;
    assign ex_ram_we   = r_ram_we;
    assign ex_wd_sel   = r_wd_sel;

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;

    logic        cpu_clk;
    logic        cpu_rst_n;
    logic        id_valid;
    logic [31:0] id_pc, id_ext, id_rD1, id_rD2;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        id_rs1_used, id_rs2_used;
    logic [3:0]  id_alu_op;
    logic [1:0]  id_npc_op, id_wd_sel;
    logic        id_npco_sel, id_alub_sel, id_rf_we, id_ram_we;
    logic        ex_is_jump;
    logic [31:0] ex_wd, mem_wd, wb_wd;
    logic [4:0]  mem_rd, wb_rd;
    logic        mem_rf_we, wb_rf_we;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_ext, ex_aluA, ex_aluB, ex_rD2;
    logic [3:0]  ex_alu_op;
    logic [1:0]  ex_npc_op, ex_wd_sel;
    logic        ex_npco_sel, ex_rf_we, ex_ram_we;
    logic [4:0]  ex_rd;
    logic        stall_id, flush_ifid;

    int total = 0;
    int bad   = 0;

    id_ex_pipe #(.XLEN(32), .REG_AW(5)) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .id_valid(id_valid), .id_pc(id_pc), .id_ext(id_ext),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .id_rD1(id_rD1), .id_rD2(id_rD2), .id_rd(id_rd),
        .id_alu_op(id_alu_op), .id_npc_op(id_npc_op), .id_npco_sel(id_npco_sel),
        .id_alub_sel(id_alub_sel), .id_rf_we(id_rf_we), .id_ram_we(id_ram_we),
        .id_wd_sel(id_wd_sel),
        .ex_is_jump(ex_is_jump), .ex_wd(ex_wd),
        .mem_rd(mem_rd), .mem_rf_we(mem_rf_we), .mem_wd(mem_wd),
        .wb_rd(wb_rd), .wb_rf_we(wb_rf_we), .wb_wd(wb_wd),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_ext(ex_ext),
        .ex_aluA(ex_aluA), .ex_aluB(ex_aluB), .ex_rD2(ex_rD2),
        .ex_alu_op(ex_alu_op), .ex_npc_op(ex_npc_op), .ex_npco_sel(ex_npco_sel),
        .ex_rd(ex_rd), .ex_rf_we(ex_rf_we), .ex_ram_we(ex_ram_we), .ex_wd_sel(ex_wd_sel),
        .stall_id(stall_id), .flush_ifid(flush_ifid)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"},  32'(ex_valid),    32'd0);
        chk({tag, ".pc"},     ex_pc,            32'd0);
        chk({tag, ".ext"},    ex_ext,           32'd0);
        chk({tag, ".aluA"},   ex_aluA,          32'd0);
        chk({tag, ".aluB"},   ex_aluB,          32'd0);
        chk({tag, ".rD2"},    ex_rD2,           32'd0);
        chk({tag, ".aluop"},  32'(ex_alu_op),   32'd0);
        chk({tag, ".npc"},    32'(ex_npc_op),   32'd0);
        chk({tag, ".npco"},   32'(ex_npco_sel), 32'd0);
        chk({tag, ".rd"},     32'(ex_rd),       32'd0);
        chk({tag, ".rfwe"},   32'(ex_rf_we),    32'd0);
        chk({tag, ".ramwe"},  32'(ex_ram_we),   32'd0);
        chk({tag, ".wdsel"},  32'(ex_wd_sel),   32'd0);
        chk({tag, ".stall"},  32'(stall_id),    32'd0);
        chk({tag, ".flush"},  32'(flush_ifid),  32'd0);
    endtask

    task automatic clear_in();
        id_valid = 0; id_pc = 0; id_ext = 0; id_rD1 = 0; id_rD2 = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_used = 0; id_rs2_used = 0;
        id_alu_op = 0; id_npc_op = 0; id_wd_sel = 0;
        id_npco_sel = 0; id_alub_sel = 0; id_rf_we = 0; id_ram_we = 0;
        ex_is_jump = 0; ex_wd = 0; mem_wd = 0; wb_wd = 0;
        mem_rd = 0; wb_rd = 0; mem_rf_we = 0; wb_rf_we = 0;
    endtask

    // Simple ID instruction: register sources, rD values, destination, writeback select.
    task automatic id_instr(input logic [4:0] rs1, input logic u1, input logic [31:0] rd1,
                            input logic [4:0] rs2, input logic u2, input logic [31:0] rd2,
                            input logic [4:0] rd, input logic [1:0] wdsel);
        id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rD1 = rd1;
        id_rs2 = rs2; id_rs2_used = u2; id_rD2 = rd2;
        id_rd = rd; id_rf_we = 1; id_wd_sel = wdsel; id_alub_sel = 0;
    endtask

    // All fields 32 bits wide so the table literals need no sizing.
    typedef struct {
        logic [31:0] v, pc, ext, rs1, rs2, u1, u2, rd1, rd2, rd, alub, rfwe, ramwe, wdsel,
                     npc, aluop, npco, jump, mrd, mwe, mwd;
        logic [31:0] x_stall, x_flush, x_valid, x_pc, x_ext, x_a, x_b, x_d2, x_rd, x_rfwe,
                     x_ramwe, x_wdsel, x_npc, x_aluop, x_npco;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int nstall;
        int done;

        // v pc ext rs1 rs2 u1 u2 rD1 rD2 rd alub rfwe ramwe wdsel npc aluop npco jump mrd mwe mwd
        // | stall flush valid pc ext aluA aluB rD2 rd rfwe ramwe wdsel npc aluop npco
        vecs[0] = '{1, 'h100, 'h4, 1, 2, 1, 1, 'h11, 'h22, 3, 0, 1, 0, 0, 0, 2, 0, 0, 0, 0, 0,
                    0, 0, 1, 'h100, 'h4, 'h11, 'h22, 'h22, 3, 1, 0, 0, 0, 2, 0};
        vecs[1] = '{1, 'h104, 'hFFFF_FFF0, 4, 5, 1, 0, 'h44, 'h55, 6, 1, 1, 0, 0, 0, 3, 0, 0,
                    0, 0, 0,
                    0, 0, 1, 'h104, 'hFFFF_FFF0, 'h44, 'hFFFF_FFF0, 'h55, 6, 1, 0, 0, 0, 3, 0};
        vecs[2] = '{1, 'h108, 'h8, 7, 8, 1, 1, 'h70, 'h80, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 1, 'h108, 'h8, 'h70, 'h8, 'h80, 0, 0, 1, 0, 0, 0, 0};
        // x0 source with a MEM writer to x0: must read as 0 despite rD1 and mem_wd.
        vecs[3] = '{1, 'h10C, 'h20, 0, 9, 1, 1, 'hBAD, 'h99, 10, 0, 1, 0, 0, 1, 5, 1, 0,
                    0, 1, 'h55,
                    0, 0, 1, 'h10C, 'h20, 0, 'h99, 'h99, 10, 1, 0, 0, 1, 5, 1};
        // Invalid ID slot: bubble with cleared data.
        vecs[4] = '{0, 'h110, 'h30, 12, 13, 1, 1, 'h1, 'h2, 11, 1, 1, 1, 1, 2, 7, 1, 0, 0, 0, 0,
                    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        // Redirect: flush, bubble.
        vecs[5] = '{1, 'h114, 'h40, 13, 14, 1, 1, 'h3, 'h4, 12, 0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0,
                    0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        vecs[6] = '{1, 'h118, 'h50, 14, 15, 1, 1, 'h1, 'h2, 16, 0, 1, 0, 2, 3, 15, 1, 0, 0, 0, 0,
                    0, 0, 1, 'h118, 'h50, 'h1, 'h2, 'h2, 16, 1, 0, 2, 3, 15, 1};
        // lw x4: left in EX for the reset-during-stall sequence below.
        vecs[7] = '{1, 'h11C, 'h8, 17, 0, 1, 0, 'h5, 'h0, 4, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,
                    0, 0, 1, 'h11C, 'h8, 'h5, 'h8, 'h0, 4, 1, 0, 1, 0, 0, 0};

        // ---------------- reset ----------------
        clear_in();
        cpu_rst_n = 1'b0;
        repeat (2) @(posedge cpu_clk);
        #1;
        chk_zero("reset");
        @(negedge cpu_clk);
        cpu_rst_n = 1'b1;

        // ---------------- table ----------------
        for (int i = 0; i < 8; i++) begin
            @(negedge cpu_clk);
            clear_in();
            id_valid = vecs[i].v[0];       id_pc = vecs[i].pc;       id_ext = vecs[i].ext;
            id_rs1 = vecs[i].rs1[4:0];     id_rs2 = vecs[i].rs2[4:0];
            id_rs1_used = vecs[i].u1[0];   id_rs2_used = vecs[i].u2[0];
            id_rD1 = vecs[i].rd1;          id_rD2 = vecs[i].rd2;     id_rd = vecs[i].rd[4:0];
            id_alub_sel = vecs[i].alub[0]; id_rf_we = vecs[i].rfwe[0];
            id_ram_we = vecs[i].ramwe[0];  id_wd_sel = vecs[i].wdsel[1:0];
            id_npc_op = vecs[i].npc[1:0];  id_alu_op = vecs[i].aluop[3:0];
            id_npco_sel = vecs[i].npco[0]; ex_is_jump = vecs[i].jump[0];
            mem_rd = vecs[i].mrd[4:0];     mem_rf_we = vecs[i].mwe[0]; mem_wd = vecs[i].mwd;
            #1;
            chk($sformatf("v%0d.stall", i), 32'(stall_id),   vecs[i].x_stall);
            chk($sformatf("v%0d.flush", i), 32'(flush_ifid), vecs[i].x_flush);
            @(posedge cpu_clk);
            #1;
            chk($sformatf("v%0d.valid", i), 32'(ex_valid),    vecs[i].x_valid);
            chk($sformatf("v%0d.pc", i),    ex_pc,            vecs[i].x_pc);
            chk($sformatf("v%0d.ext", i),   ex_ext,           vecs[i].x_ext);
            chk($sformatf("v%0d.aluA", i),  ex_aluA,          vecs[i].x_a);
            chk($sformatf("v%0d.aluB", i),  ex_aluB,          vecs[i].x_b);
            chk($sformatf("v%0d.rD2", i),   ex_rD2,           vecs[i].x_d2);
            chk($sformatf("v%0d.rd", i),    32'(ex_rd),       vecs[i].x_rd);
            chk($sformatf("v%0d.rfwe", i),  32'(ex_rf_we),    vecs[i].x_rfwe);
            chk($sformatf("v%0d.ramwe", i), 32'(ex_ram_we),   vecs[i].x_ramwe);
            chk($sformatf("v%0d.wdsel", i), 32'(ex_wd_sel),   vecs[i].x_wdsel);
            chk($sformatf("v%0d.npc", i),   32'(ex_npc_op),   vecs[i].x_npc);
            chk($sformatf("v%0d.aluop", i), 32'(ex_alu_op),   vecs[i].x_aluop);
            chk($sformatf("v%0d.npco", i),  32'(ex_npco_sel), vecs[i].x_npco);
        end

        // ---------------- reset while stalled on the load to x4 ----------------
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd4, 1'b1, 32'h4444, 5'd0, 1'b0, 32'h0, 5'd6, 2'd0);
        #1;
        chk("rststall.pre_stall", 32'(stall_id), 32'd1);
        cpu_rst_n = 1'b0;
        #1;
        chk_zero("rststall");
        @(negedge cpu_clk);
        clear_in();
        cpu_rst_n = 1'b1;

`ifdef FORWARD_EN
        // ---------------- forwarding: EX beats MEM beats WB ----------------
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd2, 1'b1, 32'h2, 5'd3, 1'b1, 32'h3, 5'd1, 2'd0);   // add x1,x2,x3
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd1, 1'b1, 32'h999, 5'd1, 1'b1, 32'h999, 5'd2, 2'd0); // add x2,x1,x1
        ex_wd = 32'h10;
        mem_rd = 5'd1; mem_rf_we = 1'b1; mem_wd = 32'h20;
        wb_rd = 5'd1;  wb_rf_we = 1'b1;  wb_wd = 32'h30;
        #1;
        chk("fwd_ex.stall", 32'(stall_id), 32'd0);
        @(posedge cpu_clk);
        #1;
        chk("fwd_ex.aluA", ex_aluA, 32'h10);
        chk("fwd_ex.aluB", ex_aluB, 32'h10);
        chk("fwd_ex.rD2",  ex_rD2,  32'h10);

        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd7, 1'b1, 32'h1, 5'd8, 1'b1, 32'h2, 5'd9, 2'd0);
        ex_wd = 32'h10;
        mem_rd = 5'd7; mem_rf_we = 1'b1; mem_wd = 32'h77;
        wb_rd = 5'd7;  wb_rf_we = 1'b1;  wb_wd = 32'h88;
        @(posedge cpu_clk);
        #1;
        chk("fwd_mem.aluA", ex_aluA, 32'h77);
        chk("fwd_mem.rD2",  ex_rD2,  32'h2);

        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd10, 1'b1, 32'h1, 5'd8, 1'b1, 32'h2, 5'd11, 2'd0);
        wb_rd = 5'd8; wb_rf_we = 1'b1; wb_wd = 32'h88;
        @(posedge cpu_clk);
        #1;
        chk("fwd_wb.aluA", ex_aluA, 32'h1);
        chk("fwd_wb.aluB", ex_aluB, 32'h88);

        // ---------------- load-use ----------------
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd5, 2'd1);   // lw x5
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd5, 1'b1, 32'h1234, 5'd0, 1'b0, 32'h0, 5'd6, 2'd0);
        ex_wd = 32'hAAAA;
        #1;
        chk("lu.stall", 32'(stall_id), 32'd1);
        @(posedge cpu_clk);
        #1;
        chk("lu.bubble", 32'(ex_valid), 32'd0);
        @(negedge cpu_clk);
        ex_wd = 32'h0;
        mem_rd = 5'd5; mem_rf_we = 1'b1; mem_wd = 32'hDEAD_BEEF;
        #1;
        chk("lu.stall_once", 32'(stall_id), 32'd0);
        @(posedge cpu_clk);
        #1;
        chk("lu.valid", 32'(ex_valid), 32'd1);
        chk("lu.aluA",  ex_aluA, 32'hDEAD_BEEF);

        // ---------------- jump beats load-use stall ----------------
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd5, 2'd1);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd5, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 5'd6, 2'd0);
        ex_is_jump = 1'b1;
        #1;
        chk("jmp.flush", 32'(flush_ifid), 32'd1);
        chk("jmp.stall", 32'(stall_id),   32'd0);
        @(posedge cpu_clk);
        #1;
        chk("jmp.valid", 32'(ex_valid), 32'd0);
        chk("jmp.rfwe",  32'(ex_rf_we), 32'd0);
`else
        // ---------------- no forwarding: stall through EX, MEM, WB ----------------
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd3, 2'd0);   // writes x3
        @(posedge cpu_clk);
        nstall = 0;
        done   = 0;
        for (int k = 0; k < 6 && done == 0; k++) begin
            @(negedge cpu_clk);
            clear_in();
            id_instr(5'd3, 1'b1, 32'h333, 5'd0, 1'b0, 32'h0, 5'd4, 2'd0);
            // The producer moves EX -> MEM -> WB -> retired, one stage per stall cycle.
            if (k == 1) begin mem_rd = 5'd3; mem_rf_we = 1'b1; end
            if (k == 2) begin wb_rd = 5'd3;  wb_rf_we = 1'b1;  end
            #1;
            if (stall_id) nstall++;
            else done = 1;
            @(posedge cpu_clk);
            #1;
            if (done == 0) chk($sformatf("nofwd.bubble%0d", k), 32'(ex_valid), 32'd0);
        end
        chk("nofwd.stall_cycles", 32'(nstall), 32'd3);
        chk("nofwd.released",     32'(done),   32'd1);
        chk("nofwd.valid",        32'(ex_valid), 32'd1);
        chk("nofwd.aluA",         ex_aluA, 32'h333);

        // ---------------- unused rs2 never stalls; used rs2 does ----------------
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd0, 1'b0, 32'h0, 5'd9, 1'b0, 32'h9, 5'd1, 2'd0);
        mem_rd = 5'd9; mem_rf_we = 1'b1;
        #1;
        chk("nofwd.rs2_unused", 32'(stall_id), 32'd0);
        id_rs2_used = 1'b1;
        #1;
        chk("nofwd.rs2_mem", 32'(stall_id), 32'd1);
        @(posedge cpu_clk);

        // ---------------- jump beats hazard stall ----------------
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd0, 1'b0, 32'h0, 5'd0, 1'b0, 32'h0, 5'd3, 2'd0);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        clear_in();
        id_instr(5'd3, 1'b1, 32'h1, 5'd0, 1'b0, 32'h0, 5'd6, 2'd0);
        ex_is_jump = 1'b1;
        #1;
        chk("jmp.flush", 32'(flush_ifid), 32'd1);
        chk("jmp.stall", 32'(stall_id),   32'd0);
        @(posedge cpu_clk);
        #1;
        chk("jmp.valid", 32'(ex_valid), 32'd0);
        chk("jmp.rfwe",  32'(ex_rf_we), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
